id_ex_pipeline_register: RTL and testbench
==========================================

ID_EX_PIPELINE_REGISTER -- requirements
Module: id_ex_pipeline_register

Interface
REQ-001 Parameter NB_DATA, default 32, data/immediate/PC width.
REQ-002 Parameter NB_REG, default 5, register address width.
REQ-003 Parameter NB_CTRL, default 8, decoded control bundle width.
REQ-004 Parameter NB_CNT, default 16, bubble counter width.
REQ-005 Port i_clk  in  1  the block's only clock; all state updates on rising edge.
REQ-006 Port i_reset  in  1  reset, asynchronous, active-high.
REQ-007 Ports i_valid  in  1  decode stage holds a valid instruction; i_stall  in  1  hold stage contents; i_flush  in  1  squash stage contents.
REQ-008 Ports i_rs_addr, i_rt_addr, i_rd_addr  in  NB_REG  decoded register addresses.
REQ-009 Ports i_rs_data, i_rt_data  in  NB_DATA  combinational register file read data.
REQ-010 Ports i_imm, i_pc  in  NB_DATA  sign-extended immediate, instruction PC+4; i_shamt  in  5  shift amount; i_ctrl  in  NB_CTRL  control bundle.
REQ-011 Ports i_wb_write  in  1, i_wb_addr  in  NB_REG, i_wb_data  in  NB_DATA  write-back port, same signals driving the register file write port.
REQ-012 Ports o_valid  out  1, o_rs_data/o_rt_data/o_imm/o_pc  out  NB_DATA, o_rs_addr/o_rt_addr/o_rd_addr  out  NB_REG, o_shamt  out  5, o_ctrl  out  NB_CTRL  registered execute-stage view.
REQ-013 Port o_bubble_count  out  NB_CNT  saturating count of bubbles issued to execute.

Function
REQ-014 Write-through bypass: captured rs data SHALL equal i_wb_data when i_wb_write=1 and i_wb_addr==i_rs_addr, else i_rs_data; same rule independently for rt.
REQ-015 Bypass SHALL apply for every address including 0 (register file has no hardwired zero).
REQ-016 Per rising edge, priority SHALL be flush > stall > load.
REQ-017 Flush: o_valid<=0, o_ctrl<=0, all other outputs hold; o_bubble_count increments.
REQ-018 Stall (no flush): every output holds its value; o_bubble_count unchanged.
REQ-019 While stalled with a held valid entry, if i_wb_write=1 and i_wb_addr matches held o_rs_addr (o_rt_addr), held o_rs_data (o_rt_data) SHALL update to i_wb_data, so a stall never leaves stale operands.
REQ-020 Load (no flush, no stall): all outputs capture inputs (with bypass), o_valid<=i_valid; if i_valid=0 then o_ctrl<=0 and o_bubble_count increments.
REQ-021 Latency exactly one cycle from decode inputs to outputs.
REQ-022 o_bubble_count SHALL saturate at 2^NB_CNT-1 and never wrap.
REQ-023 o_ctrl SHALL be all-zero whenever o_valid=0.
REQ-024 Outputs SHALL be driven only from registers; no combinational input-to-output path.

Reset
REQ-025 i_reset=1 SHALL immediately, without a clock edge, drive o_valid=0, o_ctrl=0, all data/address/shamt outputs=0, o_bubble_count=0.
REQ-026 Reset asserted mid-stall or mid-flush SHALL override both; first edge after deassertion performs a normal flush/stall/load by REQ-016.
REQ-027 Reset SHALL not count as a bubble.

Verification
REQ-028 Load: i_valid=1, rs=3 data 0x11, rt=4 data 0x22, no wb -> next edge o_valid=1, o_rs_data=0x11, o_rt_data=0x22, count 0.
REQ-029 Bypass: rs=rt=7, i_rs_data=i_rt_data=0x5, wb write addr 7 data 0xDEADBEEF -> both captured 0xDEADBEEF; repeat with addr 0 -> same bypass.
REQ-030 Stall refresh: valid entry rs=9 held by i_stall=1 for 3 cycles, wb addr 9 data 0xA5A5 in cycle 2 -> o_rs_data=0xA5A5, all other outputs unchanged, count unchanged.
REQ-031 Priority: i_flush=1 and i_stall=1 same edge with valid entry -> o_valid=0, o_ctrl=0, count +1.
REQ-032 Saturation: NB_CNT=4, 20 consecutive bubbles (i_valid=0) -> count reaches 15 and stays 15.
REQ-033 Async reset: assert i_reset between edges with o_valid=1 -> all outputs 0 before next edge; deassert with i_stall=1 -> outputs stay 0.

Source files
------------

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures decoded operands with write-through bypass,
// supports flush/stall and counts bubbles issued to execute with saturation.
module id_ex_pipeline_register #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_CTRL = 8,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [NB_REG-1:0]  i_rs_addr,
  input  logic [NB_REG-1:0]  i_rt_addr,
  input  logic [NB_REG-1:0]  i_rd_addr,
  input  logic [NB_DATA-1:0] i_rs_data,
  input  logic [NB_DATA-1:0] i_rt_data,
  input  logic [NB_DATA-1:0] i_imm,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic [4:0]         i_shamt,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic               i_wb_write,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_DATA-1:0] o_pc,
  output logic [NB_REG-1:0]  o_rs_addr,
  output logic [NB_REG-1:0]  o_rt_addr,
  output logic [NB_REG-1:0]  o_rd_addr,
  output logic [4:0]         o_shamt,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_CNT-1:0]  o_bubble_count
);

  localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);

  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_ONE;
  endfunction

  // Register file writes land in the same cycle, so forward them, address 0 included.
  function automatic logic [NB_DATA-1:0] bypass(
    input logic [NB_REG-1:0]  addr,
    input logic [NB_DATA-1:0] rf_data,
    input logic               wb_write,
    input logic [NB_REG-1:0]  wb_addr,
    input logic [NB_DATA-1:0] wb_data
  );
    return (wb_write && (wb_addr == addr)) ? wb_data : rf_data;
  endfunction

  logic               vld_p1;
  logic [NB_DATA-1:0] rs_data_p1;
  logic [NB_DATA-1:0] rt_data_p1;
  logic [NB_DATA-1:0] imm_p1;
  logic [NB_DATA-1:0] pc_p1;
  logic [NB_REG-1:0]  rs_addr_p1;
  logic [NB_REG-1:0]  rt_addr_p1;
  logic [NB_REG-1:0]  rd_addr_p1;
  logic [4:0]         shamt_p1;
  logic [NB_CTRL-1:0] ctrl_p1;
  logic [NB_CNT-1:0]  cnt_p1;

  // Decode -> execute boundary
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_p1     <= 1'b0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      pc_p1      <= '0;
      rs_addr_p1 <= '0;
      rt_addr_p1 <= '0;
      rd_addr_p1 <= '0;
      shamt_p1   <= '0;
      ctrl_p1    <= '0;
      cnt_p1     <= '0;
    end else if (i_flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      cnt_p1  <= sat_inc(cnt_p1);
    end else if (i_stall) begin
      // Keep held operands coherent with writes retiring during the stall.
      if (vld_p1 && i_wb_write) begin
        if (i_wb_addr == rs_addr_p1) rs_data_p1 <= i_wb_data;
        if (i_wb_addr == rt_addr_p1) rt_data_p1 <= i_wb_data;
      end
    end else begin
      vld_p1     <= i_valid;
      rs_data_p1 <= bypass(i_rs_addr, i_rs_data, i_wb_write, i_wb_addr, i_wb_data);
      rt_data_p1 <= bypass(i_rt_addr, i_rt_data, i_wb_write, i_wb_addr, i_wb_data);
      imm_p1     <= i_imm;
      pc_p1      <= i_pc;
      rs_addr_p1 <= i_rs_addr;
      rt_addr_p1 <= i_rt_addr;
      rd_addr_p1 <= i_rd_addr;
      shamt_p1   <= i_shamt;
      ctrl_p1    <= i_valid ? i_ctrl : '0;
      if (!i_valid) cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign o_valid        = vld_p1;
  assign o_rs_data      = rs_data_p1;
  assign o_rt_data      = rt_data_p1;
  assign o_imm          = imm_p1;
  assign o_pc           = pc_p1;
  assign o_rs_addr      = rs_addr_p1;
  assign o_rt_addr      = rt_addr_p1;
  assign o_rd_addr      = rd_addr_p1;
  assign o_shamt        = shamt_p1;
  assign o_ctrl         = ctrl_p1;
  assign o_bubble_count = cnt_p1;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed bench for id_ex_pipeline_register: load, bypass, stall refresh,
// priority, bubble saturation and asynchronous reset.
module tb_id_ex_pipeline_register;

  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int NB_CTRL = 8;
  localparam int NB_CNT  = 4;

  logic               i_clk = 1'b0;
  logic               i_reset, i_valid, i_stall, i_flush;
  logic [NB_REG-1:0]  i_rs_addr, i_rt_addr, i_rd_addr;
  logic [NB_DATA-1:0] i_rs_data, i_rt_data, i_imm, i_pc;
  logic [4:0]         i_shamt;
  logic [NB_CTRL-1:0] i_ctrl;
  logic               i_wb_write;
  logic [NB_REG-1:0]  i_wb_addr;
  logic [NB_DATA-1:0] i_wb_data;
  logic               o_valid;
  logic [NB_DATA-1:0] o_rs_data, o_rt_data, o_imm, o_pc;
  logic [NB_REG-1:0]  o_rs_addr, o_rt_addr, o_rd_addr;
  logic [4:0]         o_shamt;
  logic [NB_CTRL-1:0] o_ctrl;
  logic [NB_CNT-1:0]  o_bubble_count;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  id_ex_pipeline_register #(
    .NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_CTRL(NB_CTRL), .NB_CNT(NB_CNT)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
    .i_rd_addr(i_rd_addr), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_imm(i_imm), .i_pc(i_pc), .i_shamt(i_shamt), .i_ctrl(i_ctrl),
    .i_wb_write(i_wb_write), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_valid(o_valid), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm(o_imm), .o_pc(o_pc), .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr),
    .o_rd_addr(o_rd_addr), .o_shamt(o_shamt), .o_ctrl(o_ctrl),
    .o_bubble_count(o_bubble_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 32'(o_valid), 32'h0);
    check({tag, ".ctrl"}, 32'(o_ctrl), 32'h0);
    check({tag, ".rs_data"}, o_rs_data, 32'h0);
    check({tag, ".rt_data"}, o_rt_data, 32'h0);
    check({tag, ".imm"}, o_imm, 32'h0);
    check({tag, ".pc"}, o_pc, 32'h0);
    check({tag, ".addrs"}, {17'h0, o_rs_addr, o_rt_addr, o_rd_addr}, 32'h0);
    check({tag, ".shamt"}, 32'(o_shamt), 32'h0);
    check({tag, ".count"}, 32'(o_bubble_count), 32'h0);
  endtask

  task automatic drive(input logic vld, input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd, input logic [7:0] ctrl);
    i_valid = vld; i_rs_addr = rs; i_rs_data = rsd;
    i_rt_addr = rt; i_rt_data = rtd; i_ctrl = ctrl;
  endtask

  initial begin
    i_reset = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    i_rs_addr = '0; i_rt_addr = '0; i_rd_addr = '0;
    i_rs_data = '0; i_rt_data = '0; i_imm = '0; i_pc = '0; i_shamt = '0;
    i_ctrl = '0; i_wb_write = 1'b0; i_wb_addr = '0; i_wb_data = '0;

    #1 i_reset = 1'b1;
    #1 check_all_zero("reset_init");
    tick(); tick();
    i_reset = 1'b0;

    // Plain load, no write-back
    drive(1'b1, 5'd3, 32'h11, 5'd4, 32'h22, 8'h5A);
    i_rd_addr = 5'd5; i_imm = 32'h100; i_pc = 32'h44; i_shamt = 5'd3;
    tick();
    check("load.valid", 32'(o_valid), 32'h1);
    check("load.rs_data", o_rs_data, 32'h11);
    check("load.rt_data", o_rt_data, 32'h22);
    check("load.ctrl", 32'(o_ctrl), 32'h5A);
    check("load.imm", o_imm, 32'h100);
    check("load.pc", o_pc, 32'h44);
    check("load.addrs", {17'h0, o_rs_addr, o_rt_addr, o_rd_addr}, {17'h0, 5'd3, 5'd4, 5'd5});
    check("load.shamt", 32'(o_shamt), 32'h3);
    check("load.count", 32'(o_bubble_count), 32'h0);
    i_rs_data = 32'hBAD0BAD0;
    #1 check("no_comb_path", o_rs_data, 32'h11);

    // Write-through bypass on both operands, then on address 0
    drive(1'b1, 5'd7, 32'h5, 5'd7, 32'h5, 8'h01);
    i_wb_write = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'hDEADBEEF;
    tick();
    check("bypass7.rs", o_rs_data, 32'hDEADBEEF);
    check("bypass7.rt", o_rt_data, 32'hDEADBEEF);
    drive(1'b1, 5'd0, 32'h5, 5'd0, 32'h5, 8'h02);
    i_wb_addr = 5'd0; i_wb_data = 32'h12345678;
    tick();
    check("bypass0.rs", o_rs_data, 32'h12345678);
    check("bypass0.rt", o_rt_data, 32'h12345678);
    drive(1'b1, 5'd1, 32'h77, 5'd6, 32'h88, 8'h03);
    i_wb_addr = 5'd6; i_wb_data = 32'hCAFE;
    tick();
    check("bypass_rt_only.rs", o_rs_data, 32'h77);
    check("bypass_rt_only.rt", o_rt_data, 32'hCAFE);
    i_wb_write = 1'b0;

    // Stall with a write-back to the held rs register in the second cycle
    drive(1'b1, 5'd9, 32'h100, 5'd10, 32'h200, 8'h33);
    i_imm = 32'h77; i_pc = 32'h1000; i_rd_addr = 5'd11; i_shamt = 5'd7;
    tick();
    i_stall = 1'b1;
    drive(1'b0, 5'd2, 32'hFFFF, 5'd3, 32'hEEEE, 8'hFF);
    i_imm = 32'h0; i_pc = 32'h0;
    tick();
    check("stall1.rs", o_rs_data, 32'h100);
    i_wb_write = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'hA5A5;
    tick();
    check("stall2.rs", o_rs_data, 32'hA5A5);
    check("stall2.rt", o_rt_data, 32'h200);
    i_wb_write = 1'b0;
    tick();
    check("stall3.rs", o_rs_data, 32'hA5A5);
    check("stall3.rt", o_rt_data, 32'h200);
    check("stall3.valid", 32'(o_valid), 32'h1);
    check("stall3.ctrl", 32'(o_ctrl), 32'h33);
    check("stall3.imm", o_imm, 32'h77);
    check("stall3.pc", o_pc, 32'h1000);
    check("stall3.addrs", {17'h0, o_rs_addr, o_rt_addr, o_rd_addr}, {17'h0, 5'd9, 5'd10, 5'd11});
    check("stall3.count", 32'(o_bubble_count), 32'h0);

    // Flush wins over stall
    i_flush = 1'b1;
    tick();
    check("prio.valid", 32'(o_valid), 32'h0);
    check("prio.ctrl", 32'(o_ctrl), 32'h0);
    check("prio.count", 32'(o_bubble_count), 32'h1);
    check("prio.rs_hold", o_rs_data, 32'hA5A5);
    check("prio.imm_hold", o_imm, 32'h77);
    i_flush = 1'b0; i_stall = 1'b0;

    // Invalid load is a bubble with zero control
    drive(1'b0, 5'd12, 32'h4321, 5'd13, 32'h8765, 8'hC3);
    tick();
    check("bubble.valid", 32'(o_valid), 32'h0);
    check("bubble.ctrl", 32'(o_ctrl), 32'h0);
    check("bubble.rs", o_rs_data, 32'h4321);
    check("bubble.count", 32'(o_bubble_count), 32'h2);

    // Saturation of the 4-bit bubble counter
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("sat.count%0d", k), 32'(o_bubble_count), (2 + k > 15) ? 32'd15 : 32'(2 + k));
    end
    i_flush = 1'b1;
    tick();
    check("sat.flush", 32'(o_bubble_count), 32'd15);
    i_flush = 1'b0;

    // Asynchronous reset between edges, then release under stall
    drive(1'b1, 5'd14, 32'h55, 5'd15, 32'h66, 8'h9C);
    i_imm = 32'h9; i_pc = 32'h8; i_rd_addr = 5'd1; i_shamt = 5'd2;
    tick();
    check("pre_rst.valid", 32'(o_valid), 32'h1);
    #2 i_reset = 1'b1;
    #1 check_all_zero("async_rst");
    i_stall = 1'b1; i_flush = 1'b1;
    tick();
    check("rst_over_flush.count", 32'(o_bubble_count), 32'h0);
    i_flush = 1'b0;
    #2 i_reset = 1'b0;
    tick();
    check_all_zero("rst_release_stall");
    i_stall = 1'b0;
    tick();
    check("post_rst.valid", 32'(o_valid), 32'h1);
    check("post_rst.rs", o_rs_data, 32'h55);
    check("post_rst.count", 32'(o_bubble_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
